dmem_requester: RTL and testbench

//  MEM-stage initiator for the Data_Memory port (addr/write_data/memWrite/read_data).

---
 rtl/dmem_requester_if.sv | 32 +++
 rtl/dmem_requester.sv | 131 +++++++++++++
 tb/tb_dmem_requester.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_requester_if.sv
// Request/response and Data_Memory signals of the MEM-stage requester.
// slave = requester side, master = pipeline plus memory side.
interface dmem_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              err;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memWrite;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, err, stall,
               mem_addr, mem_write_data, mem_memWrite
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, err, stall,
               mem_addr, mem_write_data, mem_memWrite
    );
endinterface

// File: rtl/dmem_requester.sv
// MEM-stage initiator: one load/store per handshake, LATENCY memory cycles, one-cycle response.
// Optional misaligned-address check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_requester #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dmem_requester_if.slave      bus_if
);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        bus_if.req_ready      = 1'b0;
        bus_if.stall          = 1'b0;
        bus_if.resp_valid     = 1'b0;
        bus_if.resp_rdata     = '0;
        bus_if.err            = 1'b0;
        bus_if.mem_addr       = '0;
        bus_if.mem_write_data = '0;
        bus_if.mem_memWrite   = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus_if.req_ready = 1'b1;
                bus_if.stall     = bus_if.req_valid;
                if (bus_if.req_valid) begin
                    addr_d  = bus_if.req_addr;
                    wdata_d = bus_if.req_wdata;
                    write_d = bus_if.req_write;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                    // Misaligned requests bypass the memory entirely.
                    if (ALIGN_CHECK && (bus_if.req_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                bus_if.stall          = 1'b1;
                bus_if.mem_addr       = addr_q;
                bus_if.mem_write_data = wdata_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last access cycle: single write strobe, or capture load data.
                    bus_if.mem_memWrite = write_q;
                    if (!write_q) begin
                        rdata_d = bus_if.mem_read_data;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                bus_if.resp_valid = 1'b1;
                bus_if.resp_rdata = rdata_q;
                bus_if.err        = err_q;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are forced quiet for the whole reset cycle, whatever the state.
        if (rst_i) begin
            bus_if.req_ready      = 1'b0;
            bus_if.stall          = 1'b0;
            bus_if.resp_valid     = 1'b0;
            bus_if.resp_rdata     = '0;
            bus_if.err            = 1'b0;
            bus_if.mem_addr       = '0;
            bus_if.mem_write_data = '0;
            bus_if.mem_memWrite   = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_dmem_requester;

    localparam int L  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_requester #(.LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Word-organised memory attached to the mem_* port.
    logic [31:0] tbmem [64];
    bit          mem_ready = 1'b0;
    assign bus.mem_read_data = tbmem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bus.mem_memWrite) begin
            tbmem[bus.mem_addr[7:2]] <= bus.mem_write_data;
        end
    end

    // Reference model: one outstanding transaction timed from its accept cycle.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_acc = 0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_write, m_mis;
    logic [31:0] ref_mem [64];
    int          mk, mlast;

    always @(posedge clk) begin
        if (cyc == 0) for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        mk    = cyc - m_acc;
        mlast = m_mis ? 1 : L + 1;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (!m_mis && mk == L) begin
                if (m_write) ref_mem[m_addr[7:2]] = m_wdata;
                else         m_rdata = ref_mem[m_addr[7:2]];
            end
            if (mk == mlast) m_busy = 1'b0;
        end else if (bus.req_valid) begin
            m_busy  = 1'b1;
            m_acc   = cyc;
            m_addr  = bus.req_addr;
            m_wdata = bus.req_wdata;
            m_write = bus.req_write;
            m_mis   = ALN && (bus.req_addr[1:0] != 2'b00);
            m_rdata = '0;
        end
        cyc++;
    end

    // Per-cycle compare and event logs.
    int          acc_log [$];
    int          wr_cyc [$];
    logic [31:0] wr_addr [$];
    int          resp_cyc [$];
    logic [31:0] resp_data [$];
    bit          resp_err [$];
    bit          stall_hist [int];
    int          ck, clast;
    logic        e_ready, e_stall, e_rv, e_err, e_we;
    logic [31:0] e_rd, e_ma, e_wd;

    always @(negedge clk) begin
        e_ready = 0; e_stall = 0; e_rv = 0; e_err = 0; e_we = 0;
        e_rd = '0; e_ma = '0; e_wd = '0;
        if (!rst) begin
            if (!m_busy) begin
                e_ready = 1'b1;
                e_stall = bus.req_valid;
            end else begin
                ck    = cyc - m_acc;
                clast = m_mis ? 1 : L + 1;
                if (ck == clast) begin
                    e_rv  = 1'b1;
                    e_rd  = (m_write || m_mis) ? 32'd0 : m_rdata;
                    e_err = m_mis;
                end else begin
                    e_stall = 1'b1;
                    e_ma    = m_addr;
                    e_wd    = m_wdata;
                    e_we    = (ck == L) && m_write;
                end
            end
        end
        chk("req_ready",  64'(bus.req_ready),      64'(e_ready));
        chk("stall",      64'(bus.stall),          64'(e_stall));
        chk("resp_valid", 64'(bus.resp_valid),     64'(e_rv));
        chk("resp_rdata", 64'(bus.resp_rdata),     64'(e_rd));
        chk("err",        64'(bus.err),            64'(e_err));
        chk("mem_addr",   64'(bus.mem_addr),       64'(e_ma));
        chk("mem_wdata",  64'(bus.mem_write_data), 64'(e_wd));
        chk("memWrite",   64'(bus.mem_memWrite),   64'(e_we));
        stall_hist[cyc] = bus.stall;
        if (bus.req_valid && bus.req_ready) acc_log.push_back(cyc);
        if (bus.mem_memWrite) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.mem_addr);
        end
        if (bus.resp_valid) begin
            resp_cyc.push_back(cyc);
            resp_data.push_back(bus.resp_rdata);
            resp_err.push_back(bus.err);
        end
    end

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, output int n);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                n = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (n < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout got=none want=accept");
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            total++; bad++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
        @(posedge clk);
        #1;
    endtask

    int  n, wr0, rv0, acc0, got;
    bit  acc;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset held two cycles with a request pending.
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(bus.req_ready), 64'd1);
        chk("rel_stall", 64'(bus.stall), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_idle();

        // Store 0x1234 to 0x8.
        wr0 = wr_cyc.size(); rv0 = resp_cyc.size();
        do_req(1'b1, 32'h8, 32'h1234, n);
        wait_idle();
        chk("st_wr_count",  64'(wr_cyc.size() - wr0), 64'd1);
        chk("st_wr_cyc",    64'(wr_cyc[wr0]), 64'(n + 2));
        chk("st_wr_addr",   64'(wr_addr[wr0]), 64'h8);
        chk("st_resp_cyc",  64'(resp_cyc[rv0]), 64'(n + 3));
        chk("st_resp_data", 64'(resp_data[rv0]), 64'd0);
        chk("st_mem",       64'(tbmem[2]), 64'h1234);

        // Load back from 0x8.
        wr0 = wr_cyc.size(); rv0 = resp_cyc.size();
        do_req(1'b0, 32'h8, 32'h0, n);
        wait_idle();
        chk("ld_resp_cyc",  64'(resp_cyc[rv0]), 64'(n + 3));
        chk("ld_resp_data", 64'(resp_data[rv0]), 64'h1234);
        chk("ld_no_write",  64'(wr_cyc.size() - wr0), 64'd0);
        chk("ld_stall_n",   64'(stall_hist[n]), 64'd1);
        chk("ld_stall_n1",  64'(stall_hist[n + 1]), 64'd1);
        chk("ld_stall_n2",  64'(stall_hist[n + 2]), 64'd1);
        chk("ld_stall_n3",  64'(stall_hist[n + 3]), 64'd0);

        // Three back-to-back loads with valid held.
        rv0 = resp_cyc.size(); acc0 = acc_log.size(); got = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h20;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got++;
                @(posedge clk);
                #1 bus.req_addr = bus.req_addr + 32'd4;
                if (got == 3) begin
                    bus.req_valid = 1'b0;
                    break;
                end
            end
        end
        bus.req_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", 64'(acc_log.size() - acc0), 64'd3);
        chk("b2b_gap1",    64'(acc_log[acc0 + 1] - acc_log[acc0]), 64'd4);
        chk("b2b_gap2",    64'(acc_log[acc0 + 2] - acc_log[acc0 + 1]), 64'd4);
        chk("b2b_resps",   64'(resp_cyc.size() - rv0), 64'd3);

        // Store aborted by reset in its first access cycle.
        wr0 = wr_cyc.size(); rv0 = resp_cyc.size();
        do_req(1'b1, 32'h10, 32'hBEEF, n);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'(bus.req_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_write", 64'(wr_cyc.size() - wr0), 64'd0);
        chk("abort_no_resp",  64'(resp_cyc.size() - rv0), 64'd0);
        chk("abort_mem",      64'(tbmem[4]), 64'(init_word(4)));

        // Load from a misaligned address.
        wr0 = wr_cyc.size(); rv0 = resp_cyc.size();
        do_req(1'b0, 32'h6, 32'h0, n);
        wait_idle();
        chk("mis_no_write", 64'(wr_cyc.size() - wr0), 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_resp_cyc",  64'(resp_cyc[rv0]), 64'(n + 1));
        chk("mis_err",       64'(resp_err[rv0]), 64'd1);
        chk("mis_resp_data", 64'(resp_data[rv0]), 64'd0);
`else
        chk("mis_resp_cyc",  64'(resp_cyc[rv0]), 64'(n + 3));
        chk("mis_err",       64'(resp_err[rv0]), 64'd0);
        chk("mis_resp_data", 64'(resp_data[rv0]), 64'(init_word(1)));
`endif

        // Randomized traffic with occasional single-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc = bus.req_valid && bus.req_ready;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0) rst = 1'b1;
            if (!bus.req_valid || acc) begin
                bus.req_valid = ($urandom_range(0, 2) != 0);
                bus.req_write = 1'($urandom_range(0, 1));
                bus.req_addr  = 32'($urandom_range(0, 255));
                bus.req_wdata = $urandom;
            end
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
